yuv_upsample_csc: RTL

Parametrised successor to the first-milestone colour-space stage of the image decompressor. It reads one frame of 4:2:2 Y/U/V data from external SRAM, horizontally interpolates U and V to full resolution with the 6-tap filter (21, −52, 159, 159, −52, 21), converts each pixel to RGB with clipping, and writes packed RGB back to SRAM. Image geometry and base addresses are parameters; row-edge replication and output saturation are built in.

---
 rtl/yuv_upsample_csc_if.sv | 10 +
 rtl/yuv_upsample_csc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_upsample_csc_if.sv
// SRAM port bundle for the YUV 4:2:2 to RGB frame converter.
interface yuv_upsample_csc_if;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   modport master (input SRAM_read_data, output SRAM_address, SRAM_write_data, SRAM_we_n);
   modport slave  (output SRAM_read_data, input SRAM_address, SRAM_write_data, SRAM_we_n);
endinterface

// File: rtl/yuv_upsample_csc.sv
// Frame converter: 4:2:2 YUV in SRAM -> 6-tap chroma upsample -> clipped RGB back to SRAM.
// Each pixel pair takes an 8-step schedule sharing four multipliers; next-pair reads overlap the writes.
module yuv_upsample_csc #(
   parameter int          IMG_WIDTH  = 320,
   parameter int          IMG_HEIGHT = 240,
   parameter logic [17:0] Y_BASE     = 18'd0,
   parameter logic [17:0] U_BASE     = 18'd38400,
   parameter logic [17:0] V_BASE     = 18'd57600,
   parameter logic [17:0] RGB_BASE   = 18'd146944
) (
   input  logic               Clock,
   input  logic               resetn,
   input  logic               start,
   yuv_upsample_csc_if.master sram,
   output logic               busy,
   output logic               done
);
   localparam int          N      = IMG_WIDTH / 2;
   localparam logic [17:0] YW     = 18'(IMG_WIDTH / 2);
   localparam logic [17:0] CW     = 18'(IMG_WIDTH / 4);
   localparam int          I2     = (N > 2) ? 2 : N - 1;
   localparam int          I3     = (N > 3) ? 3 : N - 1;
   localparam logic [17:0] C_OFS  = 18'(I2 / 2);
   localparam logic        I2_LO  = 1'(I2 % 2);
   localparam logic        I3_LO  = 1'(I3 % 2);
   localparam logic [17:0] LAST_K = 18'(N - 1);

   localparam logic [2:0] IDLE = 3'd0, ROW_INIT = 3'd1, ROW_RUN = 3'd2, ROW_END = 3'd3, DONE = 3'd4;

   localparam logic signed [31:0] K21 = 32'sd21, KN52 = -32'sd52, K159 = 32'sd159;
   localparam logic signed [31:0] KY = 32'sd76284, KRV = 32'sd104595, KGU = 32'sd25624;
   localparam logic signed [31:0] KGV = 32'sd53281, KBU = 32'sd132251;

   logic [2:0]        state, step;
   logic [15:0]       row, pair;
   logic [17:0]       y_row, c_row, wr_ptr, addr_q, nidx, nofs;
   logic [15:0]       wd_q, rd, y_cur, y_nxt, t0, t1, t2;
   logic              we_q, nlo, last_pair, last_row;
   logic [5:0][7:0]   u_win, v_win;
   logic [7:0]        u_new, v_new, uo, vo, r0, g0, b0, r1, g1, b1;
   logic signed [31:0] acc_u, acc_v, ys, gp;
   logic signed [31:0] ma [4], mb [4], p [4];

   assign sram.SRAM_address    = addr_q;
   assign sram.SRAM_write_data = wd_q;
   assign sram.SRAM_we_n       = we_q;
   assign rd                   = sram.SRAM_read_data;

   function automatic logic [7:0] sat8(input logic signed [31:0] x);
      if (x < 0) return 8'd0;
      if (x > 255) return 8'd255;
      return x[7:0];
   endfunction

   function automatic logic signed [31:0] ex(input logic [7:0] b);
      return $signed({24'd0, b});
   endfunction

   function automatic logic [7:0] pick(input logic [15:0] w, input logic lo);
      return lo ? w[7:0] : w[15:8];
   endfunction

   // Chroma sample entering the window for the next pair, clamped to the row end
   always_comb begin
      nidx = 18'(pair) + 18'd4;
      if (nidx > LAST_K) nidx = LAST_K;
      nofs = {1'b0, nidx[17:1]};
      nlo  = nidx[0];
   end

   assign last_pair = (18'(pair) == LAST_K);
   assign last_row  = (row == 16'(IMG_HEIGHT - 1));

   // Window element i holds sample k-2+i; steps 0-2 filter, 3-5 colour-convert
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      case (step)
         3'd0: begin
            ma = '{ex(u_win[0]), ex(u_win[1]), ex(u_win[2]), ex(u_win[3])};
            mb = '{K21, KN52, K159, K159};
         end
         3'd1: begin
            ma = '{ex(u_win[4]), ex(u_win[5]), ex(v_win[0]), ex(v_win[1])};
            mb = '{KN52, K21, K21, KN52};
         end
         3'd2: begin
            ma = '{ex(v_win[2]), ex(v_win[3]), ex(v_win[4]), ex(v_win[5])};
            mb = '{K159, K159, KN52, K21};
         end
         3'd3: begin
            ma = '{ex(y_cur[15:8]) - 32'sd16, ex(v_win[2]) - 32'sd128,
                   ex(u_win[2]) - 32'sd128, ex(v_win[2]) - 32'sd128};
            mb = '{KY, KRV, KGU, KGV};
         end
         3'd4: begin
            ma = '{ex(u_win[2]) - 32'sd128, ex(y_cur[7:0]) - 32'sd16,
                   ex(vo) - 32'sd128, ex(uo) - 32'sd128};
            mb = '{KBU, KY, KRV, KGU};
         end
         3'd5: begin
            ma = '{ex(vo) - 32'sd128, ex(uo) - 32'sd128, 32'sd0, 32'sd0};
            mb = '{KGV, KBU, 32'sd0, 32'sd0};
         end
         default: ;
      endcase
      for (int i = 0; i < 4; i++) p[i] = ma[i] * mb[i];
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;  step <= '0;   row <= '0;   pair <= '0;
         y_row <= '0;    c_row <= '0;  wr_ptr <= '0;
         addr_q <= '0;   wd_q <= '0;   we_q <= 1'b1;
         busy <= 1'b0;   done <= 1'b0;
         y_cur <= '0;    y_nxt <= '0;  t0 <= '0;  t1 <= '0;  t2 <= '0;
         u_win <= '0;    v_win <= '0;  u_new <= '0; v_new <= '0;
         uo <= '0; vo <= '0; r0 <= '0; g0 <= '0; b0 <= '0; r1 <= '0; g1 <= '0; b1 <= '0;
         acc_u <= '0;    acc_v <= '0;  ys <= '0;  gp <= '0;
      end else begin
         we_q <= 1'b1;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy   <= 1'b1;
               state  <= ROW_INIT;
               step   <= '0;
               row    <= '0;
               pair   <= '0;
               y_row  <= '0;
               c_row  <= '0;
               wr_ptr <= RGB_BASE;
            end
            ROW_INIT: begin
               step <= step + 3'd1;
               case (step)
                  3'd0: addr_q <= Y_BASE + y_row;
                  3'd1: addr_q <= U_BASE + c_row;
                  3'd2: addr_q <= U_BASE + c_row + C_OFS;
                  3'd3: begin addr_q <= V_BASE + c_row;         y_cur <= rd; end
                  3'd4: begin addr_q <= V_BASE + c_row + C_OFS; t0 <= rd;    end
                  3'd5: t1 <= rd;
                  3'd6: t2 <= rd;
                  default: begin
                     // Left edge replicates sample 0 into the two taps before the row
                     u_win <= {pick(t1, I3_LO), pick(t1, I2_LO), t0[7:0], t0[15:8], t0[15:8], t0[15:8]};
                     v_win <= {pick(rd, I3_LO), pick(rd, I2_LO), t2[7:0], t2[15:8], t2[15:8], t2[15:8]};
                     state <= ROW_RUN;
                  end
               endcase
            end
            ROW_RUN: begin
               step <= step + 3'd1;
               case (step)
                  3'd0: begin
                     acc_u  <= p[0] + p[1] + p[2] + p[3];
                     addr_q <= Y_BASE + y_row + 18'(pair) + 18'd1;
                  end
                  3'd1: begin
                     acc_u  <= acc_u + p[0] + p[1];
                     acc_v  <= p[2] + p[3];
                     addr_q <= U_BASE + c_row + nofs;
                  end
                  3'd2: begin
                     acc_v  <= acc_v + p[0] + p[1] + p[2] + p[3];
                     addr_q <= V_BASE + c_row + nofs;
                  end
                  3'd3: begin
                     uo    <= sat8((acc_u + 32'sd128) >>> 8);
                     vo    <= sat8((acc_v + 32'sd128) >>> 8);
                     r0    <= sat8((p[0] + p[1]) >>> 16);
                     g0    <= sat8((p[0] - p[2] - p[3]) >>> 16);
                     ys    <= p[0];
                     y_nxt <= rd;
                  end
                  3'd4: begin
                     b0     <= sat8((ys + p[0]) >>> 16);
                     r1     <= sat8((p[1] + p[2]) >>> 16);
                     gp     <= p[1] - p[3];
                     ys     <= p[1];
                     u_new  <= pick(rd, nlo);
                     addr_q <= wr_ptr;
                     wd_q   <= {r0, g0};
                     we_q   <= 1'b0;
                     wr_ptr <= wr_ptr + 18'd1;
                  end
                  3'd5: begin
                     g1     <= sat8((gp - p[0]) >>> 16);
                     b1     <= sat8((ys + p[1]) >>> 16);
                     v_new  <= pick(rd, nlo);
                     addr_q <= wr_ptr;
                     wd_q   <= {b0, r1};
                     we_q   <= 1'b0;
                     wr_ptr <= wr_ptr + 18'd1;
                  end
                  3'd6: begin
                     addr_q <= wr_ptr;
                     wd_q   <= {g1, b1};
                     we_q   <= 1'b0;
                     wr_ptr <= wr_ptr + 18'd1;
                  end
                  default: begin
                     y_cur <= y_nxt;
                     u_win <= {u_new, u_win[5:1]};
                     v_win <= {v_new, v_win[5:1]};
                     if (last_pair) begin
                        pair <= '0;
                        if (last_row) begin
                           done  <= 1'b1;
                           busy  <= 1'b0;
                           state <= DONE;
                        end else begin
                           state <= ROW_END;
                        end
                     end else begin
                        pair <= pair + 16'd1;
                     end
                  end
               endcase
            end
            ROW_END: begin
               row   <= row + 16'd1;
               y_row <= y_row + YW;
               c_row <= c_row + CW;
               step  <= '0;
               state <= ROW_INIT;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
